// File: rtl/clk_meas_pkg.sv
// -----------------------------------------------------------------------------
// clk_meas_pkg
//   Shared definitions for the clock period meter:
//     - meas_state_e : 2-bit measurement FSM encoding
//     - DEF_CNT_W, DEF_SYNC_STAGES : default widths/depths used by the
//       interface and the top-level parameters
// -----------------------------------------------------------------------------
package clk_meas_pkg;

   // Measurement FSM states.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARM     = 2'd1,
      ST_MEASURE = 2'd2,
      ST_DONE    = 2'd3
   } meas_state_e;

   // Default counter/result width in clk cycles.
   localparam int DEF_CNT_W       = 16;

   // Default synchronizer depth on the asynchronous measured signal.
   localparam int DEF_SYNC_STAGES = 2;

endpackage : clk_meas_pkg

// File: rtl/clk_period_meter_if.sv
// -----------------------------------------------------------------------------
// clk_period_meter_if
//   Control/result bundle of the clock period meter.
//   Signals:
//     start        : 1-cycle pulse requesting one measurement
//     result_ready : consumer accepts the held result when valid && ready
//     busy         : meter is not idle
//     result_valid : result held and stable
//     period       : clk cycles between two consecutive rising edges
//     high_time    : clk cycles from the first rising edge to the next fall
//     timeout      : measurement aborted on counter saturation
//   Modports:
//     master : the requester/consumer (drives start, result_ready)
//     slave  : the meter itself (drives status and results)
//   CNT_W must match the CNT_W of the meter connected to the slave side.
// -----------------------------------------------------------------------------
interface clk_period_meter_if #(
   parameter int CNT_W = clk_meas_pkg::DEF_CNT_W
);

   logic             start;
   logic             result_ready;
   logic             busy;
   logic             result_valid;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             timeout;

   modport master (
      output start,
      output result_ready,
      input  busy,
      input  result_valid,
      input  period,
      input  high_time,
      input  timeout
   );

   modport slave (
      input  start,
      input  result_ready,
      output busy,
      output result_valid,
      output period,
      output high_time,
      output timeout
   );

endinterface : clk_period_meter_if

// File: rtl/sig_sync_edge.sv
// -----------------------------------------------------------------------------
// sig_sync_edge
//   Brings an asynchronous level into the clk domain through a flop chain and
//   derives single-cycle edge strobes from the synchronized level.
//   Parameters:
//     SYNC_STAGES : number of synchronizer flops (must be >= 2)
//   Ports:
//     clk    in  system clock
//     rst    in  asynchronous active-high reset (chain and delay flop -> 0)
//     sig_in in  asynchronous input level
//     rise   out 1 for one cycle when the synchronized level goes 0->1
//     fall   out 1 for one cycle when the synchronized level goes 1->0
//   rise and fall are decoded from flops only, so they never coincide and
//   carry no combinational path from sig_in.
// -----------------------------------------------------------------------------
module sig_sync_edge #(
   parameter int SYNC_STAGES = clk_meas_pkg::DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_in,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   lvl_dly_q;
   logic                   lvl_dly_d;
   logic                   lvl;

   // Oldest stage is the synchronized level; new samples shift in at bit 0.
   assign lvl = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], sig_in};
      lvl_dly_d = lvl;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q    <= '0;
         lvl_dly_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         lvl_dly_q <= lvl_dly_d;
      end
   end

   assign rise = lvl & ~lvl_dly_q;
   assign fall = ~lvl & lvl_dly_q;

endmodule : sig_sync_edge

// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
//   Single-shot measurement of a slow square wave (sig_in) against clk.
//   After a start pulse it waits for a rising edge, then counts clk cycles to
//   the following falling edge (high_time) and the following rising edge
//   (period). The result is held under a valid/ready handshake.
//   If the counter saturates before the measurement completes, the meter
//   finishes with timeout=1 and saturated results.
//   Parameters:
//     CNT_W       : counter and result width (saturation value 2**CNT_W-1)
//     SYNC_STAGES : synchronizer depth on sig_in (>= 2)
//   Ports:
//     clk    in  system clock, all logic on its rising edge
//     rst    in  asynchronous active-high reset
//     sig_in in  measured signal, asynchronous to clk
//     bus    slave side of clk_period_meter_if (start/ready in,
//            busy/result_valid/period/high_time/timeout out)
//   All outputs come from flops or from decoding the state register.
// -----------------------------------------------------------------------------
module clk_period_meter
   import clk_meas_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sig_in,
   clk_period_meter_if.slave    bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Edge strobes of the synchronized measured signal.
   logic sig_rise;
   logic sig_fall;

   sig_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk    (clk),
      .rst    (rst),
      .sig_in (sig_in),
      .rise   (sig_rise),
      .fall   (sig_fall)
   );

   meas_state_e      state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             hi_cap_q,    hi_cap_d;
   logic [CNT_W-1:0] hi_cnt_q,    hi_cnt_d;
   logic [CNT_W-1:0] period_q,    period_d;
   logic [CNT_W-1:0] high_time_q, high_time_d;
   logic             timeout_q,   timeout_d;

   logic [CNT_W-1:0] cnt_inc;
   logic             cnt_at_max;

   // Saturating increment; cnt never wraps.
   assign cnt_inc    = (cnt_q == CNT_MAX) ? CNT_MAX : (cnt_q + CNT_ONE);
   // Timeout is taken on the cycle whose increment reaches MAX, so that
   // with sig_in idle the meter is DONE exactly MAX cycles after entering ARM.
   assign cnt_at_max = (cnt_inc == CNT_MAX);

   // ------------------------------------------------------------------
   // Next-state and datapath
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hi_cap_d    = hi_cap_q;
      hi_cnt_d    = hi_cnt_q;
      period_d    = period_q;
      high_time_d = high_time_q;
      timeout_d   = timeout_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d  = ST_ARM;
               cnt_d    = '0;
               hi_cap_d = 1'b0;
               hi_cnt_d = '0;
            end
         end

         ST_ARM: begin
            if (sig_rise) begin
               // The rising edge is cycle zero of the period; the cycle
               // after it counts as 1.
               state_d = ST_MEASURE;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_at_max) begin
                  state_d     = ST_DONE;
                  timeout_d   = 1'b1;
                  period_d    = CNT_MAX;
                  high_time_d = CNT_MAX;
               end
            end
         end

         ST_MEASURE: begin
            if (sig_rise) begin
               state_d     = ST_DONE;
               period_d    = cnt_q;
               high_time_d = hi_cnt_q;
               timeout_d   = 1'b0;
            end else begin
               cnt_d = cnt_inc;
               // Only the first fall after the starting rise is the high time.
               if (sig_fall && !hi_cap_q) begin
                  hi_cnt_d = cnt_q;
                  hi_cap_d = 1'b1;
               end
               if (cnt_at_max) begin
                  state_d     = ST_DONE;
                  timeout_d   = 1'b1;
                  period_d    = CNT_MAX;
                  // A fall caught in this very cycle still counts.
                  high_time_d = hi_cap_d ? hi_cnt_d : CNT_MAX;
               end
            end
         end

         ST_DONE: begin
            // start is not looked at here, so a start coinciding with the
            // acknowledge is dropped.
            if (bus.result_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State and result registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         hi_cap_q    <= 1'b0;
         hi_cnt_q    <= '0;
         period_q    <= '0;
         high_time_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hi_cap_q    <= hi_cap_d;
         hi_cnt_q    <= hi_cnt_d;
         period_q    <= period_d;
         high_time_q <= high_time_d;
         timeout_q   <= timeout_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.result_valid = (state_q == ST_DONE);
   assign bus.period       = period_q;
   assign bus.high_time    = high_time_q;
   assign bus.timeout      = timeout_q;

endmodule : clk_period_meter

// File: tb/tb_clk_period_meter.sv
// -----------------------------------------------------------------------------
// tb_clk_period_meter
//   Drives clk_period_meter (CNT_W=8) from a divide-by-N square wave built on
//   the same clk, with a scoreboard of expected results that is consumed
//   whenever the DUT hands over a result (valid && ready).
// -----------------------------------------------------------------------------
module tb_clk_period_meter;

   localparam int CNT_W = 8;
   localparam int MAXV  = 255;

   typedef struct {
      int period;
      int high;
      int tmo;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sig_in;

   // sig_in source: 0 = held low, 1 = held high, 2 = divide-by-div_n of clk
   int sig_mode = 0;
   int div_n    = 8;
   int div_cnt  = 0;

   int n_vec = 0;
   int n_err = 0;

   exp_t sb_q[$];
   exp_t mon_e;
   int   cyc;

   clk_period_meter_if #(.CNT_W(CNT_W)) bus ();

   clk_period_meter #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (2)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .sig_in (sig_in),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Divider on the system clock: high for the first half of each period.
   always @(posedge clk) begin
      if (div_cnt >= div_n - 1) div_cnt <= 0;
      else                      div_cnt <= div_cnt + 1;
   end

   assign sig_in = (sig_mode == 2) ? (div_cnt < (div_n / 2)) : (sig_mode == 1);

   task automatic check_val(input string tag, input longint obs, input longint exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
      end
   endtask

   // Scoreboard side: a result is consumed at the edge where valid && ready.
   always @(negedge clk) begin
      if (!rst && bus.result_valid && bus.result_ready) begin
         if (sb_q.size() == 0) begin
            check_val("unexpected_result", 1, 0);
         end else begin
            mon_e = sb_q.pop_front();
            $display("result: period=%0d high_time=%0d timeout=%0d (want %0d/%0d/%0d)",
                     bus.period, bus.high_time, bus.timeout,
                     mon_e.period, mon_e.high, mon_e.tmo);
            check_val("period",    bus.period,    mon_e.period);
            check_val("high_time", bus.high_time, mon_e.high);
            check_val("timeout",   bus.timeout,   mon_e.tmo);
         end
      end
   end

   // One measurement: push expectation, pulse start, wait for valid (bounded),
   // optionally hold ready low for `hold` cycles with stray starts, then ack.
   // raise_at > 0 switches sig_in to constant high on that wait cycle.
   task automatic run_meas(input string name, input int e_per, input int e_hi,
                           input int e_to, input int raise_at, input int hold,
                           output int n_cyc);
      exp_t e;
      e.period = e_per;
      e.high   = e_hi;
      e.tmo    = e_to;
      sb_q.push_back(e);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check_val({name, "_busy"}, bus.busy, 1);
      n_cyc = 0;
      while (!bus.result_valid && n_cyc < 2000) begin
         @(posedge clk); #1;
         n_cyc++;
         if (n_cyc == raise_at) sig_mode = 1;
      end
      if (!bus.result_valid) begin
         check_val({name, "_valid_wait"}, 0, 1);
         void'(sb_q.pop_back());
         return;
      end
      for (int i = 0; i < hold; i++) begin
         if ((i % 5) == 2) bus.start = 1'b1;
         @(posedge clk); #1;
         bus.start = 1'b0;
         check_val({name, "_hold_valid"},  bus.result_valid, 1);
         check_val({name, "_hold_period"}, bus.period,       e_per);
         check_val({name, "_hold_high"},   bus.high_time,    e_hi);
      end
      bus.result_ready = 1'b1;
      bus.start        = (hold > 0);
      @(posedge clk); #1;
      bus.result_ready = 1'b0;
      bus.start        = 1'b0;
      check_val({name, "_valid_drop"}, bus.result_valid, 0);
      check_val({name, "_busy_drop"},  bus.busy,         0);
   endtask

   initial begin
      bus.start        = 1'b0;
      bus.result_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_busy",    bus.busy,         0);
      check_val("rst_valid",   bus.result_valid, 0);
      check_val("rst_period",  bus.period,       0);
      check_val("rst_high",    bus.high_time,    0);
      check_val("rst_timeout", bus.timeout,      0);
      rst = 1'b0;

      // 1: divide-by-8
      div_n = 8; sig_mode = 2;
      repeat (5) @(posedge clk); #1;
      run_meas("div8", 8, 4, 0, -1, 0, cyc);

      // 2: divide-by-2, three identical measurements
      div_n = 2;
      repeat (5) @(posedge clk); #1;
      for (int r = 0; r < 3; r++) run_meas("div2", 2, 1, 0, -1, 0, cyc);

      // 3: no edges at all -> timeout exactly MAX cycles after ARM
      sig_mode = 0;
      repeat (6) @(posedge clk); #1;
      run_meas("idle_lo", MAXV, MAXV, 1, -1, 0, cyc);
      check_val("idle_lo_done_cycle", cyc, MAXV);

      // 4: one rise then held high -> timeout in MEASURE, no fall captured
      sig_mode = 0;
      repeat (6) @(posedge clk); #1;
      run_meas("stuck_hi", MAXV, MAXV, 1, 5, 0, cyc);

      // 5: ready held low 20 cycles with stray starts, start with the ack
      div_n = 8; sig_mode = 2;
      repeat (6) @(posedge clk); #1;
      run_meas("hold", 8, 4, 0, -1, 20, cyc);

      // 6: async reset in the middle of MEASURE
      cyc = 0;
      while (sig_in && cyc < 50) begin @(posedge clk); #1; cyc++; end
      while (!sig_in && cyc < 50) begin @(posedge clk); #1; cyc++; end
      check_val("mid_rst_edge_found", (cyc < 50), 1);
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("mid_rst_busy_pre", bus.busy, 1);
      #2;
      rst = 1'b1;
      #1;
      check_val("mid_rst_busy",    bus.busy,         0);
      check_val("mid_rst_valid",   bus.result_valid, 0);
      check_val("mid_rst_period",  bus.period,       0);
      check_val("mid_rst_high",    bus.high_time,    0);
      check_val("mid_rst_timeout", bus.timeout,      0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (4) @(posedge clk); #1;
      run_meas("after_rst", 8, 4, 0, -1, 0, cyc);

      repeat (2) @(posedge clk); #1;
      check_val("sb_empty", sb_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_clk_period_meter
